// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types for the ALU sequencer: datapath width, register index type,
// ALU opcode encoding (plus the sequencer-only LDI) and the FSM state enum.
package alu_pkg;

    localparam int WIDTH = 9;
    localparam int NREGS = 4;

    typedef logic [1:0]       reg_idx_t;
    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_NOT  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_MOV  = 4'b0100,
        OP_SHL  = 4'b0101,
        OP_SHR  = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_ADD2 = 4'b1000,
        OP_SUB2 = 4'b1001,
        OP_MOVB = 4'b1010,
        OP_HOLD = 4'b1011,
        OP_LDI  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Anything above LDI has no meaning to either the ALU or the sequencer.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > OP_LDI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
// 4 x 9-bit register file with asynchronous reset.
// Ports:
//   i_clk, i_reset       clock, async active-high reset (clears all entries)
//   i_rd_a_sel/o_rd_a    combinational read port A
//   i_rd_b_sel/o_rd_b    combinational read port B
//   i_dbg_sel/o_dbg      combinational debug read port
//   i_wr_en/i_wr_sel/i_wr_data  synchronous write port
// Reads return the pre-edge value when a write to the same entry is pending.
module alu_regfile
    import alu_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  reg_idx_t i_rd_a_sel,
    output word_t    o_rd_a,
    input  reg_idx_t i_rd_b_sel,
    output word_t    o_rd_b,
    input  reg_idx_t i_dbg_sel,
    output word_t    o_dbg,
    input  logic     i_wr_en,
    input  reg_idx_t i_wr_sel,
    input  word_t    i_wr_data
);

    word_t r_regs [NREGS];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_regs[i_wr_sel] <= i_wr_data;
        end
    end

    assign o_rd_a = r_regs[i_rd_a_sel];
    assign o_rd_b = r_regs[i_rd_b_sel];
    assign o_dbg  = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Accepts one instruction at a time, drives an external combinational 9-bit
// ALU from the register file, writes the result back and pulses done.
// Ports:
//   clk, reset                      clock, async active-high reset
//   instr_valid/instr_ready         instruction handshake
//   instr_op/rd/rs/imm              instruction fields (rd is also operand A)
//   alu_a, alu_b, alu_op, alu_out   external ALU connection
//   done, result, zero, illegal     completion report (one-cycle pulses)
//   dbg_sel, dbg_data               combinational register-file peek
//
// state | meaning
// IDLE  | ready for an instruction
// EXEC  | ALU operands on the bus, result captured at the end of the cycle
// WB    | done/result presented, destination written at the end of the cycle
module alu_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs,
    input  logic [8:0] instr_imm,
    output logic [8:0] alu_a,
    output logic [8:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [8:0] alu_out,
    output logic       done,
    output logic [8:0] result,
    output logic       zero,
    output logic       illegal,
    input  logic [1:0] dbg_sel,
    output logic [8:0] dbg_data
);

    state_e     r_state;
    logic [3:0] r_op;
    reg_idx_t   r_rd;
    reg_idx_t   r_rs;
    word_t      r_imm;
    word_t      r_result;
    logic       r_wr_en;
    logic       r_ready;
    word_t      r_alu_a;
    word_t      r_alu_b;
    logic [3:0] r_alu_op;
    logic       r_done;
    logic       r_zero;
    logic       r_illegal;

    word_t      w_rd_a;
    word_t      w_rd_b;
    word_t      w_exec_val;
    logic       w_rf_we;

    alu_regfile u_regfile (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rd_a_sel (instr_rd),
        .o_rd_a     (w_rd_a),
        .i_rd_b_sel (instr_rs),
        .o_rd_b     (w_rd_b),
        .i_dbg_sel  (dbg_sel),
        .o_dbg      (dbg_data),
        .i_wr_en    (w_rf_we),
        .i_wr_sel   (r_rd),
        .i_wr_data  (r_result)
    );

    // LDI bypasses the ALU; HOLD reports the untouched destination value,
    // which is already sitting in the registered operand A.
    always_comb begin
        w_exec_val = alu_out;
        if (r_op == OP_LDI) begin
            w_exec_val = r_imm;
        end else if (r_op == OP_HOLD) begin
            w_exec_val = r_alu_a;
        end
    end

    assign w_rf_we = (r_state == ST_WB) && r_wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_imm     <= '0;
            r_result  <= '0;
            r_wr_en   <= 1'b0;
            r_ready   <= 1'b1;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= OP_MOV;
            r_done    <= 1'b0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_op    <= instr_op;
                        r_rd    <= instr_rd;
                        r_rs    <= instr_rs;
                        r_imm   <= instr_imm;
                        r_ready <= 1'b0;
                        if (is_illegal_op(instr_op)) begin
                            // Skip EXEC: report straight away with a zero result.
                            r_state   <= ST_WB;
                            r_result  <= '0;
                            r_zero    <= 1'b1;
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                            r_wr_en   <= 1'b0;
                        end else begin
                            r_state  <= ST_EXEC;
                            r_alu_a  <= w_rd_a;
                            r_alu_b  <= w_rd_b;
                            r_alu_op <= (instr_op == OP_LDI) ? OP_MOV : instr_op;
                            r_wr_en  <= (instr_op != OP_HOLD);
                        end
                    end
                end
                ST_EXEC: begin
                    r_result <= w_exec_val;
                    r_zero   <= (w_exec_val == '0);
                    r_done   <= 1'b1;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign done        = r_done;
    assign result      = r_result;
    assign zero        = r_zero;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic [8:0] instr_imm;
    logic [8:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [8:0] alu_out;
    logic       done, zero, illegal;
    logic [8:0] result;
    logic [1:0] dbg_sel;
    logic [8:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;
    int m_regs [4];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Arithmetic meaning of each ALU opcode, 9-bit wrap.
    function automatic int alu_ref(input int op, input int a, input int b);
        int r;
        case (op)
            0:  r = a & b;
            1:  r = a | b;
            2:  r = ~a;
            3:  r = a + b;
            4:  r = a;
            5:  r = a * 2;
            6:  r = a / 2;
            7:  r = a - b;
            8:  r = a + 2;
            9:  r = a - 2;
            10: r = b;
            default: r = a;
        endcase
        return r & 511;
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb alu_out = 9'(alu_ref(int'(alu_op), int'(alu_a), int'(alu_b)));

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Call in the first half of a low clock phase.
    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), dbg_data, m_regs[i]);
        end
    endtask

    task automatic issue(input int op, input int rd, input int rs, input int imm);
        int  guard, a, b, res, old;
        bit  bad, wr;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 4'(op);
        instr_rd    = 2'(rd);
        instr_rs    = 2'(rs);
        instr_imm   = 9'(imm);
        dbg_sel     = 2'(rd);
        guard = 0;
        while (instr_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", (guard < 20) ? 1 : 0, 1);
        a   = m_regs[rd];
        b   = m_regs[rs];
        old = m_regs[rd];
        bad = (op >= 13);
        wr  = !bad && (op != 11);
        if (bad)          res = 0;
        else if (op == 12) res = imm;
        else if (op == 11) res = a;
        else               res = alu_ref(op, a, b);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        if (bad) begin
            chk("ill_done", done, 1);
            chk("ill_flag", illegal, 1);
            chk("ill_result", result, 0);
            chk("ill_zero", zero, 1);
            @(negedge clk);
            chk("ill_done_drop", done, 0);
            chk("ill_ready", instr_ready, 1);
            chk("ill_nowrite", dbg_data, old);
        end else begin
            chk("exec_ready", instr_ready, 0);
            chk("exec_done", done, 0);
            chk("exec_alu_a", alu_a, a);
            chk("exec_alu_b", alu_b, b);
            chk("exec_alu_op", alu_op, (op == 12) ? 4 : op);
            @(negedge clk);
            chk("wb_done", done, 1);
            chk("wb_illegal", illegal, 0);
            chk("wb_result", result, res);
            chk("wb_zero", zero, (res == 0) ? 1 : 0);
            chk("wb_dbg_old", dbg_data, old);
            if (wr) m_regs[rd] = res;
            @(negedge clk);
            chk("post_done", done, 0);
            chk("post_ready", instr_ready, 1);
            chk("post_dbg_new", dbg_data, m_regs[rd]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cyc [$];
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs    = '0;
        instr_imm   = '0;
        dbg_sel     = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        #12;
        chk("rst_ready", instr_ready, 1);
        chk("rst_alu_op", alu_op, 4);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk);
        reset = 1'b0;
        check_regs("rst");

        // Directed sequence
        issue(12, 0, 0, 5);
        issue(12, 1, 0, 3);
        @(negedge clk); check_regs("ldi");
        issue(3, 0, 1, 0);
        issue(12, 2, 0, 9'h1FF);
        issue(12, 3, 0, 1);
        issue(3, 2, 3, 0);
        issue(7, 2, 3, 0);
        issue(14, 1, 2, 0);
        @(negedge clk); check_regs("illegal");
        issue(11, 1, 0, 0);
        issue(7, 1, 1, 0);
        issue(12, 1, 0, 9'h155);
        issue(5, 1, 0, 0);
        issue(6, 1, 0, 0);

        // Valid held high: accepts every 3 cycles, held instruction not re-accepted early
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 4'd11;
        instr_rd    = 2'd2;
        instr_rs    = 2'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cyc.push_back(c);
        end
        instr_valid = 1'b0;
        chk("held_done_count", done_cyc.size(), 4);
        for (int k = 1; k < done_cyc.size(); k++)
            chk("held_interval", done_cyc[k] - done_cyc[k-1], 3);
        check_regs("held");

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            int op, gap;
            op  = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) op = 12;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            issue(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 511));
        end
        @(negedge clk); check_regs("rand");

        // Reset in the middle of EXEC aborts the instruction
        issue(12, 0, 0, 9'h0AA);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 4'd3;
        instr_rd    = 2'd0;
        instr_rs    = 2'd0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", instr_ready, 1);
        chk("abort_done", done, 0);
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        check_regs("abort");
        @(negedge clk);
        chk("abort_no_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done2", done, 0);
        issue(12, 3, 0, 9'h123);
        @(negedge clk); check_regs("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencer that owns the 9-bit ALU and a 4-entry × 9-bit register file. It accepts one instruction at a time over a valid/ready handshake and drives the ALU operand and opcode lines from the register file. It captures the ALU result, writes it back to the destination register and reports completion with a zero flag. It sits between the instruction source (testbench or fetch unit) and the existing combinational 9-bit ALU, which it instantiates externally through ports.

## Interface
- NREGS, 4, register-file depth; fixed at 4, giving a 2-bit index.
- WIDTH, 9, datapath width; must match the ALU.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- instr_valid  input  1  instruction present on instr_op/rd/rs/imm.
- instr_ready  output  1  sequencer can accept; reset value 1.
- instr_op  input  4  opcode (ALU encoding 0000–1011, plus 1100 LDI).
- instr_rd  input  2  destination register, also operand A index.
- instr_rs  input  2  operand B index.
- instr_imm  input  9  immediate, used only by LDI.
- alu_a, alu_b  output  9 each  ALU operands; reset value 0.
- alu_op  output  4  ALU opcode; reset value 4'b0100 (MOV, harmless).
- alu_out  input  9  ALU result (combinational from alu_a/alu_b/alu_op).
- done  output  1  one-cycle completion pulse; reset value 0.
- result  output  9  written-back value, valid while done; reset value 0.
- zero  output  1  result == 0, valid while done; reset value 0.
- illegal  output  1  one-cycle pulse for opcodes 1101–1111; reset value 0.
- dbg_sel  input  2  register-file debug read index.
- dbg_data  output  9  combinational read of R[dbg_sel].

## Operation
- FSM states: IDLE, EXEC, WB.
- **IDLE**
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch op, rd, rs and imm into the instruction register, then go to EXEC.
  - No instr_valid: stay in IDLE.
- **EXEC**
  - instr_ready = 0.
  - alu_a = R[rd], alu_b = R[rs], alu_op = op.
  - Latch alu_out into the result register, then go to WB.
  - LDI: latch imm instead of alu_out; alu_op is held at MOV.
- **WB**
  - instr_ready = 0.
  - R[rd] ← result register, done = 1, zero = (result == 0), then go to IDLE.
- Opcode 1011 (ALU hold) is a NOP: done pulses, result = R[rd] unchanged, no register write.
- Opcodes 1101–1111:
  - Go from IDLE to WB with no EXEC cycle.
  - illegal = 1 and done = 1 in that WB cycle.
  - No register write; result = 0, zero = 1.
- rd == rs is legal: both ALU operands read the same register.
- ADD/SUB wrap modulo 512 and no carry is reported, e.g. 0x1FF + 1 = 0, 0 − 1 = 0x1FF.
- Shifts are logical: SHL drops bit 8, SHR inserts 0.
- A write in WB and a debug read of the same register in the same cycle: dbg_data shows the old value; the new value appears after the edge.
- instr_valid asserted while instr_ready = 0 is ignored. The source must hold its instruction until accepted.

## Timing
- Accept at edge N. EXEC runs in cycle N+1, done is high in cycle N+2, instr_ready returns high in cycle N+3.
- Normal latency: 2 cycles from accept to done. Throughput: 1 instruction per 3 cycles.
- Illegal opcodes: done in cycle N+1.
- alu_a, alu_b and alu_op are registered outputs of the state/instruction register and are stable for the whole EXEC cycle. The ALU is combinational, so alu_out is sampled at the end of EXEC.
- Reset asserted at any point:
  - State returns to IDLE immediately.
  - R0–R3, the instruction register and the result register all clear to 0.
  - done and illegal drop to 0 immediately. An in-flight instruction is aborted with no write and no done.
- First accept is possible on the first rising edge after reset deasserts.

## Structure
- **alu_pkg**
  - WIDTH = 9 and the opcode enum: AND, OR, NOT, ADD, MOV, SHL, SHR, SUB, ADD2, SUB2, MOVB, HOLD, LDI.
  - State enum: IDLE, EXEC, WB.
  - reg_idx_t: 2-bit register index.
- **alu_regfile** (sub-module)
  - 4 × 9 storage with async reset.
  - Two combinational read ports (A, B), one debug read port, one synchronous write port.

## Test plan
- After reset, LDI R0 = 5, then LDI R1 = 3 → done pulses with result = 5 and 3; dbg reads R0 = 5, R1 = 3.
- ADD R0, R1 → in EXEC alu_a = 5, alu_b = 3, alu_op = 0011; done at accept+2 with result 8, zero = 0; R0 = 8.
- LDI R2 = 0x1FF, LDI R3 = 1, then ADD R2, R3 → result 0, zero = 1.
- Then SUB R2, R3 → result 0x1FF.
- Opcode 1110 → illegal and done pulse at accept+1; all registers unchanged.
- Opcode 1011 → done pulses; R[rd] unchanged.
- Hold instr_valid high continuously → instructions accepted exactly every 3 cycles.
- Assert reset during EXEC of ADD → no done; all registers read 0; instr_ready = 1 immediately.
